// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the buffered UART transmitter: the core pushes bytes and
// watches the FIFO status flags.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_enable;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (
        output wr_enable, wr_data,
        input  full, empty, count, overflow
    );

    modport slave (
        input  wr_enable, wr_data,
        output full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a circular-buffer FIFO feeding a two-state
// serializer that drains queued bytes back-to-back.
module uart_tx_fifo #(
    parameter int CLK_PER_BIT = 868,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic          clock,
    input  logic          reset,
    uart_tx_fifo_if.slave wr_bus,
    output logic          uart_busy,
    output logic          uart_tx,
    output logic [2:0]    led
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [9:0] LAST_CLK = 10'(CLK_PER_BIT - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [9:0]            clk_cnt;
    logic [9:0]            clk_cnt_next;
    logic [3:0]            bit_cnt;
    logic [3:0]            bit_cnt_next;
    logic [9:0]            shift;
    logic [9:0]            shift_next;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign push  = wr_bus.wr_enable && !full;

    // A write while full is dropped even if the serializer pops in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_bus.wr_enable && full) begin
                overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '1;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
        end
    end

    // The shift register is loaded with the whole frame, start bit in the LSB,
    // and refills with ones so the line rests high once the stop bit is out.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = {1'b1, mem[rd_ptr], 1'b0};
                    state_next = SEND;
                end
            end
            SEND: begin
                if (clk_cnt == LAST_CLK) begin
                    clk_cnt_next = '0;
                    shift_next   = {1'b1, shift[9:1]};
                    if (bit_cnt == 4'd9) begin
                        bit_cnt_next = '0;
                        state_next   = IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 10'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign uart_tx   = shift[0];
    assign uart_busy = (state == SEND);
    assign led       = overflow ? 3'b100 : ((state == SEND) ? 3'b010 : 3'b001);

    assign wr_bus.full     = full;
    assign wr_bus.empty    = empty;
    assign wr_bus.count    = count;
    assign wr_bus.overflow = overflow;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit: a cycle table for the
// fill/overflow sequence plus hand-written multi-cycle scenarios.
module tb_uart_tx_fifo;
    logic       clock;
    logic       reset;
    logic       uart_busy;
    logic       uart_tx;
    logic [2:0] led;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_tx_fifo #(
        .CLK_PER_BIT(4),
        .DEPTH_LOG2 (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .wr_bus   (bus),
        .uart_busy(uart_busy),
        .uart_tx  (uart_tx),
        .led      (led)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic       en;
        logic [7:0] data;
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       busy;
        logic       tx;
        logic [2:0] led;
    } vec_t;

    typedef logic [7:0] byte_q_t[$];

    vec_t    vecs[22];
    byte_q_t rx_q;
    int      rx_frame_err = 0;
    bit      rx_aborted;

    // Independent line receiver: samples mid-bit, drops frames cut by reset.
    task automatic rxWait(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (!reset) rx_aborted = 1'b1;
        end
    endtask

    initial begin : receiver
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (reset === 1'b1 && uart_tx === 1'b0) begin
                rx_aborted = 1'b0;
                rxWait(2);
                if (uart_tx !== 1'b0 && !rx_aborted) rx_frame_err++;
                for (int i = 0; i < 8; i++) begin
                    rxWait(4);
                    b[i] = uart_tx;
                end
                rxWait(4);
                if (!rx_aborted) begin
                    if (uart_tx !== 1'b1) rx_frame_err++;
                    else rx_q.push_back(b);
                end
            end
        end
    end

    task automatic applyStimulus(input logic en, input logic [7:0] data);
        bus.wr_enable = en;
        bus.wr_data   = data;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitDrain(input string name, input int limit);
        int n = 0;
        while (!(bus.empty === 1'b1 && uart_busy === 1'b0) && n < limit) begin
            applyStimulus(1'b0, 8'h00);
            n++;
        end
        checkOutput({name, "_drained"}, 32'(bus.empty === 1'b1 && uart_busy === 1'b0), 32'd1);
    endtask

    task automatic checkRx(input string name, input byte_q_t exp_q);
        checkOutput({name, "_rx_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checkOutput($sformatf("%s_rx_byte%0d", name, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        rx_q.delete();
    endtask

    initial begin : main
        byte_q_t    exp_q;
        logic [9:0] frame55;
        int         tx_errs;
        int         busy_cycles;
        int         bb_hi;
        int         bb_gap;
        int         sent;
        int         max_occ;
        int         tx_lows;
        int         busy_highs;
        logic [7:0] d;

        vecs[0]  = '{1'b1, 8'hEE, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001};
        vecs[1]  = '{1'b0, 8'h00, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
        for (int i = 0; i < 16; i++) begin
            vecs[2 + i] = '{1'b1, 8'(i), 5'(i + 1), (i == 15), 1'b0, 1'b0, 1'b1, (i >= 7), 3'b010};
        end
        vecs[18] = '{1'b1, 8'h10, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100};
        vecs[19] = '{1'b1, 8'h11, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100};
        vecs[20] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100};
        vecs[21] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100};

        reset = 1'b0;
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("rst_tx",    32'(uart_tx),      32'd1);
        checkOutput("rst_busy",  32'(uart_busy),    32'd0);
        checkOutput("rst_empty", 32'(bus.empty),    32'd1);
        checkOutput("rst_full",  32'(bus.full),     32'd0);
        checkOutput("rst_count", 32'(bus.count),    32'd0);
        checkOutput("rst_ovf",   32'(bus.overflow), 32'd0);
        checkOutput("rst_led",   32'(led),          32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00);

        // Single byte: start bit two cycles after the write, 40 busy cycles.
        frame55 = 10'b1010101010;
        applyStimulus(1'b1, 8'h55);
        checkOutput("single_count_n1", 32'(bus.count), 32'd1);
        checkOutput("single_tx_n1",    32'(uart_tx),   32'd1);
        checkOutput("single_busy_n1",  32'(uart_busy), 32'd0);
        applyStimulus(1'b0, 8'h00);
        tx_errs     = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (uart_tx !== frame55[i / 4]) tx_errs++;
            if (uart_busy === 1'b1) busy_cycles++;
            applyStimulus(1'b0, 8'h00);
        end
        checkOutput("single_tx_bits",    32'(tx_errs),     32'd0);
        checkOutput("single_busy_len",   32'(busy_cycles), 32'd40);
        checkOutput("single_busy_after", 32'(uart_busy),   32'd0);
        checkOutput("single_empty",      32'(bus.empty),   32'd1);
        checkOutput("single_tx_idle",    32'(uart_tx),     32'd1);
        exp_q = '{8'h55};
        checkRx("single", exp_q);

        // Fill while the serializer is busy with 0xEE, then overflow twice.
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].en, vecs[i].data);
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.count),    32'(vecs[i].count));
            checkOutput($sformatf("vec%0d_full", i),  32'(bus.full),     32'(vecs[i].full));
            checkOutput($sformatf("vec%0d_empty", i), 32'(bus.empty),    32'(vecs[i].empty));
            checkOutput($sformatf("vec%0d_ovf", i),   32'(bus.overflow), 32'(vecs[i].ovf));
            checkOutput($sformatf("vec%0d_busy", i),  32'(uart_busy),    32'(vecs[i].busy));
            checkOutput($sformatf("vec%0d_tx", i),    32'(uart_tx),      32'(vecs[i].tx));
            checkOutput($sformatf("vec%0d_led", i),   32'(led),          32'(vecs[i].led));
        end
        waitDrain("fill", 2000);
        exp_q = '{8'hEE};
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        checkRx("fill", exp_q);
        checkOutput("fill_ovf_sticky", 32'(bus.overflow), 32'd1);
        checkOutput("fill_led_sticky", 32'(led),          32'd4);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00);
        checkOutput("ovf_clear_ovf", 32'(bus.overflow), 32'd0);
        checkOutput("ovf_clear_led", 32'(led),          32'd1);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00);

        // Back-to-back: one idle cycle between frames, nothing more.
        bb_hi  = 0;
        bb_gap = 0;
        applyStimulus(1'b1, 8'hA5);
        applyStimulus(1'b1, 8'h3C);
        checkOutput("b2b_count_pop_push", 32'(bus.count), 32'd1);
        if (uart_busy === 1'b1) bb_hi++;
        applyStimulus(1'b1, 8'hFF);
        checkOutput("b2b_count_two", 32'(bus.count), 32'd2);
        if (uart_busy === 1'b1) bb_hi++;
        for (int n = 0; n < 400 && !(bus.empty === 1'b1 && uart_busy === 1'b0); n++) begin
            applyStimulus(1'b0, 8'h00);
            if (uart_busy === 1'b1) bb_hi++;
            else if (bus.empty === 1'b0) bb_gap++;
        end
        checkOutput("b2b_busy_cycles", 32'(bb_hi),  32'd120);
        checkOutput("b2b_gap_cycles",  32'(bb_gap), 32'd2);
        waitDrain("b2b", 10);
        exp_q = '{8'hA5, 8'h3C, 8'hFF};
        checkRx("b2b", exp_q);

        // Simultaneous write and pop with one byte waiting.
        applyStimulus(1'b1, 8'h42);
        checkOutput("simul_count_before", 32'(bus.count), 32'd1);
        checkOutput("simul_busy_before",  32'(uart_busy), 32'd0);
        applyStimulus(1'b1, 8'h7E);
        checkOutput("simul_count_after", 32'(bus.count), 32'd1);
        checkOutput("simul_busy_after",  32'(uart_busy), 32'd1);
        waitDrain("simul", 200);
        exp_q = '{8'h42, 8'h7E};
        checkRx("simul", exp_q);

        // Wrap-around: 40 bytes trickled in, occupancy kept low.
        sent    = 0;
        max_occ = 0;
        exp_q.delete();
        for (int n = 0; n < 4000 && !(sent == 40 && bus.empty === 1'b1 && uart_busy === 1'b0); n++) begin
            if (sent < 40 && bus.count <= 5'd1) begin
                d = 8'(sent * 37 + 5);
                exp_q.push_back(d);
                applyStimulus(1'b1, d);
                sent++;
            end else begin
                applyStimulus(1'b0, 8'h00);
            end
            if (int'(bus.count) > max_occ) max_occ = int'(bus.count);
        end
        checkOutput("wrap_sent",    32'(sent), 32'd40);
        checkOutput("wrap_max_occ", 32'(max_occ <= 3), 32'd1);
        waitDrain("wrap", 100);
        checkRx("wrap", exp_q);

        // Reset during data bit 4 of 0xC3 with more bytes queued behind it.
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b1, 8'h11);
        applyStimulus(1'b1, 8'h22);
        applyStimulus(1'b1, 8'h33);
        applyStimulus(1'b1, 8'h44);
        for (int n = 0; n < 17; n++) applyStimulus(1'b0, 8'h00);
        checkOutput("midrst_bit4_tx",  32'(uart_tx),   32'd0);
        checkOutput("midrst_count_pre", 32'(bus.count), 32'd4);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00);
        checkOutput("midrst_tx",    32'(uart_tx),   32'd1);
        checkOutput("midrst_count", 32'(bus.count), 32'd0);
        checkOutput("midrst_busy",  32'(uart_busy), 32'd0);
        checkOutput("midrst_empty", 32'(bus.empty), 32'd1);
        reset = 1'b1;
        tx_lows    = 0;
        busy_highs = 0;
        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'b0, 8'h00);
            if (uart_tx !== 1'b1) tx_lows++;
            if (uart_busy !== 1'b0) busy_highs++;
        end
        checkOutput("midrst_quiet_tx",   32'(tx_lows),     32'd0);
        checkOutput("midrst_quiet_busy", 32'(busy_highs),  32'd0);
        checkOutput("midrst_rx_none",    32'(rx_q.size()), 32'd0);
        applyStimulus(1'b1, 8'h99);
        waitDrain("after_rst", 200);
        exp_q = '{8'h99};
        checkRx("after_rst", exp_q);

        checkOutput("rx_framing", 32'(rx_frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
